sp_ctrl: RTL and testbench

SP_CTRL -- requirements
Module: sp_ctrl

---
 rtl/sp_ctrl.sv | 95 +++++++++
 tb/tb_sp_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ctrl.sv
// sp_ctrl: four-state sequencer that decodes one instruction at a time, drives an
// external combinational ALU from registered operands and writes the result back.
module sp_ctrl #(
  parameter int NREG = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_res,
  output logic        done,
  output logic        err,
  output logic        zero,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  // Only the fields the datapath uses are latched; rb lives in imm[1:0].
  typedef struct packed {
    logic [2:0] opc;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [7:0] imm;
  } ins_t;

  state_t     state;
  ins_t       ins;
  logic [7:0] res;
  logic [7:0] rf [NREG];

  logic [1:0] rb;
  logic       rsvd;

  assign rb       = ins.imm[1:0];
  assign rsvd     = (ins.opc[2:1] == 2'b11);
  assign dbg_data = rf[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ins         <= '0;
      instr_ready <= 1'b1;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      zero        <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          ins         <= '{opc: instr[15:13], rd: instr[12:11], ra: instr[10:9], imm: instr[7:0]};
          instr_ready <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          // Operands are sampled here, before any writeback of this instruction.
          alu_op <= {5'b0, ins.opc};
          case (ins.opc)
            3'b000:  begin alu_a <= rf[ins.ra]; alu_b <= '0;     end
            3'b001:  begin alu_a <= ins.imm;    alu_b <= '0;     end
            default: begin alu_a <= rf[ins.ra]; alu_b <= rf[rb]; end
          endcase
          state <= EXEC;
        end
        EXEC: begin
          res   <= alu_res;
          state <= WB;
        end
        WB: begin
          done <= 1'b1;
          if (rsvd) err <= 1'b1;
          else begin
            rf[ins.rd] <= res;
            zero       <= (res == 8'h00);
          end
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ctrl.sv
// Bench for sp_ctrl: directed spec scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-level model.
module tb_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  alu_op, alu_a, alu_b, alu_res;
  logic        done, err, zero;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  sp_ctrl #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .done(done), .err(err), .zero(zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // External ALU seen by the controller.
  always_comb begin
    case (alu_op[2:0])
      3'd0, 3'd1: alu_res = alu_a;
      3'd2:       alu_res = alu_a + alu_b;
      3'd3:       alu_res = alu_a & alu_b;
      3'd4:       alu_res = alu_a - alu_b;
      3'd5:       alu_res = alu_a | alu_b;
      default:    alu_res = 8'hC3;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] spec_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0, 3'd1: return a;
      3'd2:       return a + b;
      3'd3:       return a & b;
      3'd4:       return a - b;
      3'd5:       return a | b;
      default:    return 8'h00;
    endcase
  endfunction

  // Instruction-level model: one instruction in flight, retiring 3 edges after acceptance.
  logic [7:0] m_rf [4];
  int         age;
  logic [2:0] m_opc;
  logic [1:0] m_rd;
  logic [7:0] m_a, m_b, m_res;
  logic [7:0] e_op, e_a, e_b;
  logic       e_done, e_err, e_zero, ab_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= -1;
      for (int i = 0; i < 4; i++) m_rf[i] <= 8'h00;
      e_done <= 1'b0; e_err <= 1'b0; e_zero <= 1'b0;
      e_op <= 8'h00; e_a <= 8'h00; e_b <= 8'h00; ab_known <= 1'b1;
      m_opc <= '0; m_rd <= '0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else begin
      e_done <= 1'b0;
      e_err  <= 1'b0;
      if (age >= 0) begin
        age <= (age == 2) ? -1 : age + 1;
        if (age == 0) begin
          e_op <= {5'b0, m_opc}; e_a <= m_a; e_b <= m_b; ab_known <= (m_opc < 3'd6);
        end
        if (age == 2) begin
          e_done <= 1'b1;
          if (m_opc >= 3'd6) e_err <= 1'b1;
          else begin
            m_rf[m_rd] <= m_res;
            e_zero     <= (m_res == 8'h00);
          end
        end
      end else if (instr_valid) begin
        m_opc <= instr[15:13];
        m_rd  <= instr[12:11];
        m_a   <= (instr[15:13] == 3'd1) ? instr[7:0] : m_rf[instr[10:9]];
        m_b   <= (instr[15:13] <= 3'd1) ? 8'h00 : m_rf[instr[1:0]];
        m_res <= spec_res(instr[15:13],
                          (instr[15:13] == 3'd1) ? instr[7:0] : m_rf[instr[10:9]],
                          (instr[15:13] <= 3'd1) ? 8'h00 : m_rf[instr[1:0]]);
        age   <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", instr_ready, (age == -1));
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("zero", zero, e_zero);
      chk("dbg_data", dbg_data, m_rf[dbg_sel]);
      chk("alu_op", alu_op, e_op);
      if (ab_known) begin
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
      end
    end
  end

  function automatic logic [15:0] rop(input logic [2:0] o, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    return {o, d, a, 7'b0, b};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] d, input logic [7:0] imm);
    return {3'b001, d, 2'b00, 1'b0, imm};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [1:0] s, output logic [7:0] v);
    dbg_sel = s; #1; v = dbg_data;
  endtask

  // Issue one instruction and wait for retirement; lat counts edges from acceptance.
  task automatic issue(input logic [15:0] w, output int lat, output logic [7:0] ea,
                       output logic [7:0] eb, output logic eerr);
    int n = 0;
    ea = 8'h00; eb = 8'h00;
    while (!instr_ready && n < 50) begin step(); n++; end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr = w; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (lat == 2) begin ea = alu_a; eb = alu_b; end
      step(); lat++;
    end
    eerr = err;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rc, dc, cyc;
    logic [7:0] ea, eb, v;
    logic ee;

    step(); step();
    rst_n = 1'b1; chk_en = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_zero", zero, 0);
    chk("rst_alu_a", alu_a, 0);
    peek(2'd3, v); chk("rst_r3", v, 8'h00);

    // LOADI 7F, LOADI 01, ADD -> 0x80
    issue(ldi(2'd1, 8'h7F), lat, ea, eb, ee); chk("lat_ldi1", lat, 4);
    issue(ldi(2'd2, 8'h01), lat, ea, eb, ee); chk("lat_ldi2", lat, 4);
    issue(rop(3'd2, 2'd3, 2'd1, 2'd2), lat, ea, eb, ee); chk("lat_add", lat, 4);
    peek(2'd3, v); chk("add_r3", v, 8'h80);
    chk("add_zero", zero, 0);

    // SUB R0 = R0 - R0 reads pre-instruction operands
    issue(ldi(2'd0, 8'h05), lat, ea, eb, ee);
    issue(rop(3'd4, 2'd0, 2'd0, 2'd0), lat, ea, eb, ee);
    chk("sub_a", ea, 8'h05); chk("sub_b", eb, 8'h05);
    peek(2'd0, v); chk("sub_r0", v, 8'h00);
    chk("sub_zero", zero, 1);

    // Wrap to zero, then OR
    issue(ldi(2'd1, 8'hFF), lat, ea, eb, ee);
    issue(ldi(2'd2, 8'h01), lat, ea, eb, ee);
    issue(rop(3'd2, 2'd1, 2'd1, 2'd2), lat, ea, eb, ee);
    peek(2'd1, v); chk("wrap_r1", v, 8'h00); chk("wrap_zero", zero, 1);
    issue(rop(3'd5, 2'd2, 2'd1, 2'd2), lat, ea, eb, ee);
    peek(2'd2, v); chk("or_r2", v, 8'h01); chk("or_zero", zero, 0);

    // Reserved opcode leaves R1 and zero alone
    issue(ldi(2'd1, 8'h3C), lat, ea, eb, ee);
    issue(ldi(2'd2, 8'h00), lat, ea, eb, ee);
    issue(rop(3'd6, 2'd1, 2'd0, 2'd0), lat, ea, eb, ee);
    chk("rsv_err", ee, 1); chk("rsv_lat", lat, 4);
    peek(2'd1, v); chk("rsv_r1", v, 8'h3C); chk("rsv_zero", zero, 1);
    step(); chk("rsv_done_pulse", done, 0); chk("rsv_err_pulse", err, 0);

    // instr_valid held high: ADD R1 += R2 runs exactly once per acceptance
    issue(ldi(2'd1, 8'h00), lat, ea, eb, ee);
    issue(ldi(2'd2, 8'h01), lat, ea, eb, ee);
    instr = rop(3'd2, 2'd1, 2'd1, 2'd2); instr_valid = 1'b1;
    rc = 0; dc = 0; cyc = 0;
    while (dc < 5 && cyc < 100) begin
      step(); cyc++;
      if (instr_ready) rc++;
      if (done) dc++;
    end
    instr_valid = 1'b0;
    chk("hold_cycles", cyc, 20); chk("hold_ready_cnt", rc, 5);
    peek(2'd1, v); chk("hold_r1", v, 8'h05);

    // Reset during EXEC of ADD R3 aborts it
    issue(ldi(2'd3, 8'h11), lat, ea, eb, ee);
    instr = rop(3'd2, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; #1;
    chk("abort_ready", instr_ready, 1);
    for (int s = 0; s < 4; s++) begin
      peek(s[1:0], v); chk("abort_dbg", v, 8'h00);
    end
    dc = 0;
    for (int k = 0; k < 6; k++) begin step(); if (done) dc++; end
    chk("abort_no_done", dc, 0);

    // Randomized run, checked by the per-cycle model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = 16'($urandom);
      dbg_sel = 2'($urandom);
      step();
    end
    instr_valid = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
